// File: rtl/arb_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// enc4 returns the position of the lowest set bit of a nibble.
package arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef logic [N_REQ-1:0] req_vec_t;

  // Callers gate the result with |v, so an all-zero input may return any index.
  function automatic logic [1:0] enc4(input logic [3:0] v);
    logic [1:0] pos;
    if (v[0]) begin
      pos = 2'd0;
    end else if (v[1]) begin
      pos = 2'd1;
    end else if (v[2]) begin
      pos = 2'd2;
    end else begin
      pos = 2'd3;
    end
    return pos;
  endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter16_if import arb_pkg::*; ();

  logic              en;
  req_vec_t          req;
  req_vec_t          gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_valid;
  logic              busy;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, busy
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, busy
  );

endinterface

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: the first set bit of req at or after ptr, wrapping mod 16.
// The rotated vector is encoded as four nibbles, and a second-level encoder selects the nibble.
module rr_pick16 import arb_pkg::*; (
  input  req_vec_t         req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  req_vec_t   rot;
  logic [3:0] grp_any;
  logic [1:0] grp_lo [4];
  logic [1:0] grp_sel;

  // Rotating right by ptr moves requester ptr to bit 0, which gives it the highest priority.
  always_comb begin
    rot = req_vec_t'({req, req} >> ptr);
  end

  always_comb begin
    for (int g = 0; g < 4; g++) begin
      grp_any[g] = |rot[4*g +: 4];
      grp_lo[g]  = enc4(rot[4*g +: 4]);
    end
  end

  always_comb begin
    grp_sel = enc4(grp_any);
    any     = |grp_any;
    idx     = {grp_sel, grp_lo[grp_sel]} + ptr;
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters. It issues registered grants with a hold limit and
// inserts one idle turnaround cycle between consecutive grants.
module rr_arbiter16 import arb_pkg::*; #(
  parameter int unsigned N        = 16,
  parameter int unsigned IDXW     = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter16_if.slave bus
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_t      state_q;
  logic [N-1:0]    gnt_q;
  logic [IDXW-1:0] idx_q;
  logic            valid_q;
  logic            busy_q;
  logic [IDXW-1:0] ptr_q;
  logic [CntW-1:0] hold_q;

  logic            pick_any;
  logic [IDXW-1:0] pick_idx;
  logic            req_held;
  logic            hold_limit;

  rr_pick16 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    req_held   = bus.req[idx_q];
    hold_limit = (MAX_HOLD != 0) && (hold_q == CntW'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.en && pick_any) begin
            state_q <= BUSY;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << pick_idx;
            idx_q   <= pick_idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            hold_q  <= '0;
          end
        end
        BUSY: begin
          // No preemption: only the holder's own request and the hold limit end a grant.
          if (!req_held || hold_limit) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= idx_q + 1'b1;
            hold_q  <= '0;
          end else begin
            hold_q  <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed testbench for rr_arbiter16. It runs a vector table on a MAX_HOLD=8 instance
// and hand-written sequences for the hold limit, mid-grant reset and a MAX_HOLD=1 rotation.
module tb_rr_arbiter16;
  import arb_pkg::*;

  typedef struct packed {
    logic        en;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        valid;
    logic        busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs [15];

  always #5 clk = ~clk;

  rr_arbiter16_if bus8 ();
  rr_arbiter16_if bus1 ();

  rr_arbiter16 #(.MAX_HOLD(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  rr_arbiter16 #(.MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [15:0] ag, input logic [3:0] ai, input logic av,
                       input logic ab,
                       input logic [15:0] eg, input logic [3:0] ei, input logic ev,
                       input logic eb);
    logic ok;
    ok = (ag == eg) && (av == ev) && (ab == eb) && (!ev || (ai == ei)) &&
         ($countones(ag) <= 1) && (ag[ai] == av);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%0b busy=%0b, want gnt=%h idx=%0d valid=%0b busy=%0b",
               name, ag, ai, av, ab, eg, ei, ev, eb);
    end
  endtask

  task automatic check8(input string name, input logic [15:0] eg, input logic [3:0] ei,
                        input logic ev, input logic eb);
    check(name, bus8.gnt, bus8.gnt_idx, bus8.gnt_valid, bus8.busy, eg, ei, ev, eb);
  endtask

  initial begin
    // The table starts right after reset release with ptr=0.
    vecs[0]  = '{1'b1, 16'h0010, 16'h0010, 4'd4, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 16'h0008, 16'h0008, 4'd3, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 16'h0208, 16'h0008, 4'd3, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 16'h0200, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 16'h0200, 16'h0200, 4'd9, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 16'h0120, 16'h0020, 4'd5, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 16'h0120, 16'h0020, 4'd5, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 16'h0100, 16'h0000, 4'd0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 16'h0100, 16'h0100, 4'd8, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus8.en   = 1'b1;
    bus8.req  = 16'hFFFF;
    bus1.en   = 1'b1;
    bus1.req  = 16'h0000;

    for (int i = 0; i < 3; i++) begin
      step();
      check8("in_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus8.en  = vecs[i].en;
      bus8.req = vecs[i].req;
      step();
      check8($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].valid, vecs[i].busy);
    end

    // Return ptr to 0 before the hold-limit sequence.
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    bus8.en  = 1'b1;
    bus8.req = 16'h8001;
    for (int c = 1; c <= 28; c++) begin
      int m;
      step();
      m = c % 18;
      if (m >= 1 && m <= 8) begin
        check8($sformatf("hold_c%0d", c), 16'h0001, 4'd0, 1'b1, 1'b1);
      end else if (m >= 10 && m <= 17) begin
        check8($sformatf("hold_c%0d", c), 16'h8000, 4'd15, 1'b1, 1'b1);
      end else begin
        check8($sformatf("hold_c%0d", c), 16'h0000, 4'd0, 1'b0, 1'b0);
      end
    end

    // Idx 15 is granted and ptr=1, so the next winner shows whether reset cleared ptr.
    #2 rst_n = 1'b0;
    #1 check8("midrst_drop", 16'h0000, 4'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    step();
    check8("post_rst_ptr0", 16'h0001, 4'd0, 1'b1, 1'b1);
    bus8.req = 16'h0000;

    bus1.req = 16'hFFFF;
    for (int c = 1; c <= 33; c++) begin
      logic [15:0] eg;
      logic [3:0]  ei;
      step();
      if (c % 2 == 1) begin
        ei = 4'((c - 1) / 2);
        eg = 16'h0001 << ei;
        check($sformatf("rot_c%0d", c), bus1.gnt, bus1.gnt_idx, bus1.gnt_valid, bus1.busy,
              eg, ei, 1'b1, 1'b1);
      end else begin
        check($sformatf("rot_c%0d", c), bus1.gnt, bus1.gnt_idx, bus1.gnt_valid, bus1.busy,
              16'h0000, 4'd0, 1'b0, 1'b0);
      end
    end
    bus1.req = 16'h0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Wraps the 16→4 priority-encoding datapath with a rotating priority pointer, a grant/hold state machine and a hold-time limit.
- Downstream logic uses gnt_idx to steer the shared resource, for example as a mux select.
- All outputs are registered.

Parameters:
- N, 16, number of requesters; fixed at 16 in this revision.
- IDXW, 4, width of gnt_idx; equals log2(N).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held. 0 means unlimited.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  arbitration enable. When low, no new grant is issued.
- req  input  N  request vector; bit i is requester i.
- gnt  output  N  one-hot grant; all zero when no grant is active.
- gnt_idx  output  IDXW  binary index of the granted requester. Valid only while gnt_valid=1.
- gnt_valid  output  1  a grant is active.
- busy  output  1  state is BUSY.

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is asynchronous and active-low (rst_n).
  - Reset forces: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0, busy=0, ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops the grant immediately, without waiting for a clock edge.
- State IDLE:
  - Transition condition: en=1 and |req=1 at a rising edge.
  - Winner = first set bit of req searching ptr, ptr+1, … wrapping mod N (ptr has highest priority).
  - At that edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, busy=1, hold_cnt=0, state moves to BUSY.
  - Latency: req sampled at edge k gives gnt visible after edge k.
- State BUSY:
  - Grant is held. req bits of other requesters and en have no effect; there is no preemption.
  - Each edge with req[gnt_idx]=1 increments hold_cnt.
  - Release happens at the first edge where either:
    - req[gnt_idx]=0, or
    - MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1.
  - On release: gnt=0, gnt_valid=0, busy=0, ptr=(gnt_idx+1) mod N with wrap 15→0, state moves to IDLE.
  - Grant duration: 1..MAX_HOLD cycles.
- Inter-grant gap:
  - Exactly one cycle with gnt_valid=0 separates consecutive grants when requests remain pending.
  - This bus-turnaround cycle is intentional.
- Fairness:
  - A requester that hit the hold limit and keeps requesting has lowest priority in the next arbitration.
  - With all 16 requesting continuously, each is served once per 16 grants, in ascending index order from ptr.
- Boundary cases:
  - req=0 in IDLE: stay in IDLE; outputs unchanged (zero).
  - Single requester held continuously with MAX_HOLD=8: 8 cycles granted, 1 gap, then re-granted.
  - en deasserted during BUSY: current grant completes normally. No new grant is issued until en=1.
  - Winner drops req in the first BUSY cycle: grant lasts exactly 1 cycle.
- Invariant: gnt is always one-hot or zero, and gnt[gnt_idx]==gnt_valid.

Decomposition:
- Package arb_pkg holds:
  - localparams N_REQ=16 and IDX_W=4;
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - typedef logic [N_REQ-1:0] req_vec_t.
- Sub-module rr_pick16 (combinational):
  - Inputs: req, ptr. Outputs: any, idx.
  - Implementation: rotate req right by ptr, encode the lowest set bit using the 4×4-bit encoder plus group-select structure, then add ptr mod 16.
  - Unit-testable on its own.

Test Plan:
- Reset, single request:
  - Stimulus: assert rst_n=0 while req=16'hFFFF, then release rst_n; en=1, req=16'h0010.
  - Required: gnt=0 throughout reset; after the first edge following release, gnt=16'h0010, gnt_idx=4, gnt_valid=1.
- Full rotation:
  - Stimulus: en=1, req=16'hFFFF held, MAX_HOLD=1.
  - Required: gnt_idx sequence 0,1,2,…,15,0 with a 1-cycle gap between grants, i.e. a grant every 2 cycles.
- Hold limit:
  - Stimulus: req=16'h8001 held, MAX_HOLD=8, ptr=0.
  - Required: idx 0 granted for 8 cycles, gap, idx 15 for 8 cycles, gap, idx 0 again. Wrap 15→0 verified.
- Early release:
  - Stimulus: idx 3 granted; req[3] dropped after 2 cycles while req[9]=1.
  - Required: grant lasts 2 cycles, gap, then gnt_idx=9.
- Enable gating:
  - Stimulus: en dropped during an idx 5 grant, req=16'h0120.
  - Required: idx 5 completes; no grant while en=0; grant to idx 8 one edge after en returns to 1.
- Mid-grant reset:
  - Stimulus: rst_n pulsed low asynchronously, between edges, during a grant.
  - Required: gnt=0 immediately; first grant after reset uses ptr=0.
